comparator_scan: RTL and testbench

COMPARATOR_SCAN -- requirements
Module: comparator_scan

---
 rtl/comparator_scan.sv | 129 ++++++++++++
 tb/tb_comparator_scan.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_scan.sv
// Purpose: compares a latched key against a stream of RAM beats and keeps gt/eq/lt counts plus the first-match index.
// Latency: one cycle from an accepted beat to its flags. Backpressure: in_ready is high only while scanning; in_valid low stalls.
// Build option: COMPARATOR_SCAN_SIGNED_EN adds signed_mode, which selects a two's-complement compare for that scan.
module comparator_scan #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_t,
`ifdef COMPARATOR_SCAN_SIGNED_EN
    input  logic              signed_mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  ramout,
    input  logic              in_last,
    output logic              out_valid,
    output logic              gt,
    output logic              eq,
    output logic              lt,
    output logic [ADDR_W:0]   gt_cnt,
    output logic [ADDR_W:0]   eq_cnt,
    output logic [ADDR_W:0]   lt_cnt,
    output logic              found,
    output logic [ADDR_W-1:0] found_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  key;
    logic [ADDR_W-1:0] beat_idx;
    logic [WIDTH-1:0]  key_cmp;
    logic [WIDTH-1:0]  ram_cmp;
    logic              key_gt;
    logic              key_eq;
    logic              last_beat;

`ifdef COMPARATOR_SCAN_SIGNED_EN
    logic signed_q;
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign key_cmp = {key[WIDTH-1] ^ signed_q, key[WIDTH-2:0]};
    assign ram_cmp = {ramout[WIDTH-1] ^ signed_q, ramout[WIDTH-2:0]};
`else
    assign key_cmp = key;
    assign ram_cmp = ramout;
`endif

    assign key_gt    = key_cmp > ram_cmp;
    assign key_eq    = key_cmp == ram_cmp;
    // The final addressable beat closes the scan even without in_last.
    assign last_beat = in_last || (beat_idx == {ADDR_W{1'b1}});
    assign in_ready  = (state == RUN);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key       <= '0;
            beat_idx  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            lt_cnt    <= '0;
            found     <= 1'b0;
            found_idx <= '0;
`ifdef COMPARATOR_SCAN_SIGNED_EN
            signed_q  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key       <= data_t;
`ifdef COMPARATOR_SCAN_SIGNED_EN
                        signed_q  <= signed_mode;
`endif
                        beat_idx  <= '0;
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        gt_cnt    <= '0;
                        eq_cnt    <= '0;
                        lt_cnt    <= '0;
                        found     <= 1'b0;
                        found_idx <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        gt        <= key_gt;
                        eq        <= key_eq;
                        lt        <= !key_gt && !key_eq;
                        if (key_gt)
                            gt_cnt <= gt_cnt + 1'b1;
                        else if (key_eq)
                            eq_cnt <= eq_cnt + 1'b1;
                        else
                            lt_cnt <= lt_cnt + 1'b1;
                        if (key_eq && !found) begin
                            found     <= 1'b1;
                            found_idx <= beat_idx;
                        end
                        beat_idx <= beat_idx + 1'b1;
                        if (last_beat) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_scan.sv
// Directed bench for comparator_scan (WIDTH=8, ADDR_W=4): inputs change 1ns after a rising edge, outputs checked there.
module tb_comparator_scan;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  data_t;
`ifdef COMPARATOR_SCAN_SIGNED_EN
    logic              signed_mode;
`endif
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  ramout;
    logic              in_last;
    logic              out_valid;
    logic              gt, eq, lt;
    logic [ADDR_W:0]   gt_cnt, eq_cnt, lt_cnt;
    logic              found;
    logic [ADDR_W-1:0] found_idx;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    comparator_scan #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_t    (data_t),
`ifdef COMPARATOR_SCAN_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ramout    (ramout),
        .in_last   (in_last),
        .out_valid (out_valid),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt),
        .lt_cnt    (lt_cnt),
        .found     (found),
        .found_idx (found_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [7:0] key);
        start  = 1'b1;
        data_t = key;
        tick();
        start  = 1'b0;
        data_t = 8'h11;
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("ready_in_run", {31'd0, in_ready}, 1);
    endtask

    // Present one beat, then check flags, out_valid and done on the next edge.
    task automatic beat(input string tag, input logic [7:0] v, input logic last,
                        input logic [2:0] exp_f, input logic exp_done);
        in_valid = 1'b1;
        ramout   = v;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_ov"},   {31'd0, out_valid}, 1);
        chk({tag, "_flag"}, {29'd0, gt, eq, lt}, {29'd0, exp_f});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    endtask

    task automatic chk_counts(input string tag, input int g, input int e, input int l,
                              input logic f, input int fi);
        chk({tag, "_gtc"},  {27'd0, gt_cnt}, g);
        chk({tag, "_eqc"},  {27'd0, eq_cnt}, e);
        chk({tag, "_ltc"},  {27'd0, lt_cnt}, l);
        chk({tag, "_fnd"},  {31'd0, found}, {31'd0, f});
        chk({tag, "_fidx"}, {28'd0, found_idx}, fi);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_t = '0;
        in_valid = 1'b0; ramout = '0; in_last = 1'b0;
`ifdef COMPARATOR_SCAN_SIGNED_EN
        signed_mode = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        chk("rst_ov", {31'd0, out_valid}, 0);
        chk("rst_flags", {29'd0, gt, eq, lt}, 0);
        chk("rst_busy_done", {30'd0, busy, done}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk_counts("rst", 0, 0, 0, 1'b0, 0);

        // Basic scan with two matches; the first match index must stick.
        do_start(8'h5A);
        beat("s1b0", 8'h55, 1'b0, 3'b100, 1'b0);
        beat("s1b1", 8'h5A, 1'b0, 3'b010, 1'b0);
        chk("s1_fidx_early", {28'd0, found_idx}, 1);
        beat("s1b2", 8'hAA, 1'b0, 3'b001, 1'b0);
        beat("s1b3", 8'h5A, 1'b1, 3'b010, 1'b1);
        chk_counts("s1", 1, 2, 1, 1'b1, 1);
        chk("s1_busy_done_state", {31'd0, busy}, 1);
        tick();
        chk("s1_idle_busy", {31'd0, busy}, 0);
        chk("s1_ov_clear", {30'd0, out_valid, done}, 0);
        chk("s1_hold_flags", {29'd0, gt, eq, lt}, 3'b010);
        chk_counts("s1_hold", 1, 2, 1, 1'b1, 1);

        // Gapped stream around the MSB boundary.
        do_start(8'h80);
        beat("s2b0", 8'h7F, 1'b0, 3'b100, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s2_gap_ov", {31'd0, out_valid}, 0);
            chk("s2_gap_hold", {29'd0, gt, eq, lt}, 3'b100);
        end
        beat("s2b1", 8'h80, 1'b0, 3'b010, 1'b0);
        tick(); tick();
        chk("s2_gap2_ov", {31'd0, out_valid}, 0);
        beat("s2b2", 8'h81, 1'b1, 3'b001, 1'b1);
        chk_counts("s2", 1, 1, 1, 1'b1, 1);
        tick();

        // Sixteen beats with no in_last: the last index closes the scan.
        do_start(8'h00);
        for (int i = 0; i < 15; i++) begin
            beat("s3_mid", 8'hFF, 1'b0, 3'b001, 1'b0);
        end
        beat("s3_last", 8'hFF, 1'b0, 3'b001, 1'b1);
        chk_counts("s3", 0, 0, 16, 1'b0, 0);
        tick();
        chk("s3_idle", {31'd0, busy}, 0);

        // Reset mid-scan, with a beat offered in the reset cycle.
        do_start(8'h33);
        beat("s4b0", 8'h33, 1'b0, 3'b010, 1'b0);
        beat("s4b1", 8'h10, 1'b0, 3'b100, 1'b0);
        rst = 1'b1; in_valid = 1'b1; ramout = 8'h33; in_last = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("s4_rst_ov_done", {30'd0, out_valid, done}, 0);
        chk("s4_rst_flags", {29'd0, gt, eq, lt}, 0);
        chk("s4_rst_busy", {30'd0, busy, in_ready}, 0);
        chk_counts("s4_rst", 0, 0, 0, 1'b0, 0);
        tick();
        chk("s4_no_done", {30'd0, out_valid, done}, 0);
        do_start(8'h10);
        beat("s4n", 8'h33, 1'b1, 3'b001, 1'b1);
        chk_counts("s4n", 0, 0, 1, 1'b0, 0);

        // start while busy (DONE, then RUN) must be ignored.
        start = 1'b1; data_t = 8'h11;
        tick();
        start = 1'b0;
        chk("s5_done_start_ignored", {31'd0, busy}, 0);
        do_start(8'h20);
        beat("s5b0", 8'h20, 1'b0, 3'b010, 1'b0);
        start = 1'b1; data_t = 8'h11;
        beat("s5b1", 8'h11, 1'b0, 3'b100, 1'b0);
        start = 1'b0;
        beat("s5b2", 8'h11, 1'b1, 3'b100, 1'b1);
        chk_counts("s5", 2, 1, 0, 1'b1, 0);
        tick();

        // Full-width unsigned compare.
        do_start(8'h7F);
        beat("s6u", 8'h80, 1'b1, 3'b001, 1'b1);
        tick();
        do_start(8'hFF);
        beat("s6w", 8'h00, 1'b1, 3'b100, 1'b1);
        tick();
`ifdef COMPARATOR_SCAN_SIGNED_EN
        signed_mode = 1'b1;
        do_start(8'h7F);
        signed_mode = 1'b0;
        beat("s7s", 8'h80, 1'b1, 3'b100, 1'b1);
        tick();
        do_start(8'h7F);
        beat("s7u", 8'h80, 1'b1, 3'b001, 1'b1);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
